// File: rtl/sha_pkg.sv
// sha_pkg: shared definitions for the SHA datapath blocks.
// Holds the rotate/shift mode encodings and the stage-split helpers for rot_pipe.
package sha_pkg;

    typedef enum logic [1:0] {
        MODE_ROR = 2'b00,
        MODE_ROL = 2'b01,
        MODE_SHR = 2'b10,
        MODE_SHL = 2'b11
    } rot_mode_t;

    // Number of amount bits handled by stage k; earlier stages absorb the remainder.
    function automatic int grp_nb(input int k, input int aw, input int st);
        return aw / st + ((k < aw % st) ? 1 : 0);
    endfunction

    function automatic int grp_lo(input int k, input int aw, input int st);
        return k * (aw / st) + ((k < aw % st) ? k : aw % st);
    endfunction

endpackage

// File: rtl/rot_stage.sv
// rot_stage: combinational group of binary sub-shifts covering amount bits LO..LO+NB-1.
// amt holds only this group's bits; bit i selects a move by 2**(LO+i).
module rot_stage
    import sha_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LO    = 0,
    parameter int NB    = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [NB-1:0]    amt,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = data;
        for (int i = 0; i < NB; i++) begin
            if (amt[i]) begin
                result = (mode == MODE_ROR) ? ((result >> (1 << (LO + i))) | (result << (WIDTH - (1 << (LO + i))))) :
                         (mode == MODE_ROL) ? ((result << (1 << (LO + i))) | (result >> (WIDTH - (1 << (LO + i))))) :
                         (mode == MODE_SHR) ? (result >> (1 << (LO + i))) :
                                              (result << (1 << (LO + i)));
            end
        end
    end

endmodule

// File: rtl/rot_pipe.sv
// rot_pipe: pipelined runtime-amount rotate/shift unit with valid/ready flow control.
// Each stage applies its sub-shift group before its register and forwards only the amount bits still pending.
module rot_pipe
    import sha_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 2,
    localparam int AW     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = grp_lo(k, AW, STAGES);
        localparam int NB = grp_nb(k, AW, STAGES);
        localparam int RW = AW - LO;
        logic             v, go, nxt, vin;
        logic [WIDTH-1:0] din, dsh, d;
        logic [RW-1:0]    ain;
        logic [1:0]       mi;
        if (k == 0) begin : g_src
            assign vin = in_valid;
            assign din = in_data;
            assign ain = in_amt;
            assign mi  = in_mode;
        end else begin : g_src
            assign vin = g_st[k-1].v;
            assign din = g_st[k-1].d;
            assign ain = g_st[k-1].g_car.a;
            assign mi  = g_st[k-1].g_car.m;
        end
        // The final stage has no pending amount or mode to carry.
        if (k == STAGES - 1) begin : g_car
            assign nxt = out_ready;
        end else begin : g_car
            logic [RW-NB-1:0] a;
            logic [1:0]       m;
            assign nxt = g_st[k+1].go;
            always_ff @(posedge clk) begin
                if (go) begin
                    a <= ain[RW-1:NB];
                    m <= mi;
                end
            end
        end
        assign go = !v || nxt;
        rot_stage #(.WIDTH(WIDTH), .LO(LO), .NB(NB)) u_stage (
            .data   (din),
            .amt    (ain[NB-1:0]),
            .mode   (mi),
            .result (dsh)
        );
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) v <= 1'b0;
            else if (go) v <= vin;
        end
        always_ff @(posedge clk) begin
            if (go) d <= dsh;
        end
    end

    assign in_ready  = g_st[0].go;
    assign out_valid = g_st[STAGES-1].v;
    assign out_data  = g_st[STAGES-1].d;

endmodule

// File: tb/tb_rot_pipe.sv
// tb_rot_pipe: checks rot_pipe in three configurations (32/2, 64/6, 8/1) against a
// bit-level reference model, with directed vectors, stall, reset and random backpressure runs.
module tb_rot_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv [3];
    logic        orr [3];
    logic [63:0] id [3];
    logic [5:0]  ia [3];
    logic [1:0]  im [3];
    logic [2:0]  ir, ov;
    logic [31:0] od0;
    logic [63:0] od1;
    logic [7:0]  od2;
    logic [63:0] od [3];
    int          wd [3] = '{32, 64, 8};
    int          total = 0, bad = 0, cyc = 0;
    int          n_out [3] = '{0, 0, 0};
    int          ocyc0 [$];

    typedef struct { int k; logic [63:0] e; } sb_t;
    sb_t sb [$];

    typedef struct { logic [31:0] d; int a; int m; logic [31:0] e; } vec_t;
    vec_t vt [12];

    always #5 clk = ~clk;

    assign od[0] = {32'b0, od0};
    assign od[1] = od1;
    assign od[2] = {56'b0, od2};

    rot_pipe #(.WIDTH(32), .STAGES(2)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0][31:0]),
        .in_amt(ia[0][4:0]), .in_mode(im[0]), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od0));
    rot_pipe #(.WIDTH(64), .STAGES(6)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .in_amt(ia[1]), .in_mode(im[1]), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od1));
    rot_pipe #(.WIDTH(8), .STAGES(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2][7:0]),
        .in_amt(ia[2][2:0]), .in_mode(im[2]), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od2));

    // Reference: each result bit picked straight from the operand by index arithmetic.
    function automatic logic [63:0] ref_op(input logic [63:0] x, input int n, input int md, input int w);
        logic [63:0] r = '0;
        for (int i = 0; i < w; i++) begin
            if (md == 0) r[i] = x[(i + n) % w];
            else if (md == 1) r[i] = x[(i - n + w) % w];
            else if (md == 2) r[i] = (i + n < w) ? x[i + n] : 1'b0;
            else if (i >= n) r[i] = x[i - n];
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int k, input logic [63:0] d, input int a, input int m, output bit acc);
        id[k] = d;
        ia[k] = 6'(a);
        im[k] = 2'(m);
        iv[k] = 1'b1;
        @(negedge clk);
        acc = ir[k];
        tick();
    endtask

    // Scoreboard: expected results queued at input transfer, popped in order at output transfer.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) sb.delete();
        else begin
            for (int k = 0; k < 3; k++) begin
                if (iv[k] && ir[k]) sb.push_back('{k, ref_op(id[k], int'(ia[k]), int'(im[k]), wd[k])});
                if (ov[k] && orr[k]) begin
                    int j;
                    j = -1;
                    for (int p = sb.size() - 1; p >= 0; p--) if (sb[p].k == k) j = p;
                    if (j < 0) begin
                        total++;
                        bad++;
                        $display("FAIL out%0d_unexpected got=%h exp=none", k, od[k]);
                    end else begin
                        chk($sformatf("out%0d_data", k), od[k], sb[j].e);
                        sb.delete(j);
                    end
                    n_out[k]++;
                    if (k == 0) ocyc0.push_back(cyc);
                end
            end
        end
    end

    initial begin
        bit acc;
        int lat, base, i, nacc;
        logic [63:0] hold;
        logic [31:0] st [4];
        vt[0]  = '{32'h80000001, 1,  0, 32'hC0000000};
        vt[1]  = '{32'h12345678, 8,  1, 32'h34567812};
        vt[2]  = '{32'h80000000, 31, 2, 32'h00000001};
        vt[3]  = '{32'hFFFFFFFF, 4,  3, 32'hFFFFFFF0};
        vt[4]  = '{32'hDEADBEEF, 0,  0, 32'hDEADBEEF};
        vt[5]  = '{32'hDEADBEEF, 0,  1, 32'hDEADBEEF};
        vt[6]  = '{32'hDEADBEEF, 0,  2, 32'hDEADBEEF};
        vt[7]  = '{32'hDEADBEEF, 0,  3, 32'hDEADBEEF};
        vt[8]  = '{32'h12345678, 4,  0, 32'h81234567};
        vt[9]  = '{32'h80000000, 1,  1, 32'h00000001};
        vt[10] = '{32'h00000001, 31, 0, 32'h00000002};
        vt[11] = '{32'hDEADBEEF, 16, 1, 32'hBEEFDEAD};
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0;
            orr[k] = 1'b1;
            id[k] = '0;
            ia[k] = '0;
            im[k] = '0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_ov%0d", k), ov[k], 1'b0);
            chk($sformatf("reset_rdy%0d", k), ir[k], 1'b1);
        end

        // Directed vectors, one at a time, with latency check.
        for (int v = 0; v < 12; v++) begin
            offer(0, {32'b0, vt[v].d}, vt[v].a, vt[v].m, acc);
            iv[0] = 1'b0;
            chk($sformatf("vec%0d_acc", v), acc, 1'b1);
            lat = 1;
            while (!ov[0] && lat < 10) begin
                tick();
                lat++;
            end
            chk($sformatf("vec%0d_lat", v), lat, 2);
            chk($sformatf("vec%0d_data", v), od[0], {32'b0, vt[v].e});
            tick();
        end

        // 16 back-to-back random operations at full throughput.
        ocyc0.delete();
        for (int n = 0; n < 16; n++) begin
            offer(0, {32'b0, $urandom}, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)), acc);
            chk($sformatf("stream_rdy%0d", n), acc, 1'b1);
        end
        iv[0] = 1'b0;
        for (int t = 0; t < 10 && ocyc0.size() < 16; t++) tick();
        chk("stream_cnt", ocyc0.size(), 16);
        chk("stream_span", ocyc0[ocyc0.size() - 1] - ocyc0[0], 15);

        // Stall: out_ready low, four ops offered, only two fit.
        for (int n = 0; n < 4; n++) st[n] = $urandom;
        orr[0] = 1'b0;
        base = n_out[0];
        i = 0;
        for (int c = 0; c < 6; c++) begin
            offer(0, {32'b0, st[i]}, i + 3, i % 4, acc);
            if (acc) i++;
        end
        chk("stall_acc", i, 2);
        chk("stall_rdy", ir[0], 1'b0);
        chk("stall_ov", ov[0], 1'b1);
        chk("stall_data", od[0], ref_op({32'b0, st[0]}, 3, 0, 32));
        hold = od[0];
        tick();
        tick();
        chk("stall_hold", od[0], hold);
        orr[0] = 1'b1;
        for (int c = 0; c < 20 && i < 4; c++) begin
            offer(0, {32'b0, st[i]}, i + 3, i % 4, acc);
            if (acc) i++;
        end
        iv[0] = 1'b0;
        chk("stall_all_acc", i, 4);
        for (int t = 0; t < 10 && n_out[0] < base + 4; t++) tick();
        chk("stall_drain", n_out[0] - base, 4);

        // Reset with two operations in flight.
        orr[0] = 1'b0;
        i = 0;
        for (int c = 0; c < 4 && i < 2; c++) begin
            offer(0, {32'b0, $urandom}, 5, 0, acc);
            if (acc) i++;
        end
        iv[0] = 1'b0;
        chk("rst_inflight", ov[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ov", ov[0], 1'b0);
        chk("rst_async_rdy", ir[0], 1'b1);
        base = n_out[0];
        tick();
        rst_n = 1'b1;
        orr[0] = 1'b1;
        repeat (8) tick();
        chk("rst_no_stale", n_out[0] - base, 0);
        chk("rst_ov_low", ov[0], 1'b0);

        // Random valid/ready traffic.
        base = n_out[0];
        nacc = 0;
        acc = 1'b1;
        for (int c = 0; c < 60; c++) begin
            orr[0] = 1'($urandom_range(0, 1));
            if (acc || !iv[0]) begin
                id[0] = {32'b0, $urandom};
                ia[0] = 6'($urandom_range(0, 31));
                im[0] = 2'($urandom_range(0, 3));
                iv[0] = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            acc = iv[0] && ir[0];
            if (acc) nacc++;
            tick();
        end
        iv[0] = 1'b0;
        orr[0] = 1'b1;
        for (int t = 0; t < 10 && n_out[0] < base + nacc; t++) tick();
        chk("bp_cnt", n_out[0] - base, nacc);

        // Exhaustive amounts and modes for the wide and narrow configurations.
        for (int k = 1; k < 3; k++) begin
            base = n_out[k];
            for (int m = 0; m < 4; m++) begin
                for (int a = 0; a < wd[k]; a++) begin
                    offer(k, {$urandom, $urandom}, a, m, acc);
                    chk($sformatf("cfg%0d_rdy_m%0d_a%0d", k, m, a), acc, 1'b1);
                end
            end
            iv[k] = 1'b0;
            for (int t = 0; t < 20 && n_out[k] < base + 4 * wd[k]; t++) tick();
            chk($sformatf("cfg%0d_cnt", k), n_out[k] - base, 4 * wd[k]);
        end
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rot_pipe.md
ROT_PIPE -- requirements
Module: rot_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; SHALL be a power of two, 8..64.
REQ-002 Parameter STAGES, default 2, number of pipeline register stages; SHALL be 1..log2(WIDTH).
REQ-003 Localparam AW = log2(WIDTH): shift-amount width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream presents an operation.
REQ-007 in_ready  output  1  block accepts the operation this cycle.
REQ-008 in_data  input  WIDTH  operand.
REQ-009 in_amt  input  AW  runtime shift/rotate amount, 0..WIDTH-1.
REQ-010 in_mode  input  2  00 ROR, 01 ROL, 10 SHR (logical), 11 SHL.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_data  output  WIDTH  result.

Function
REQ-014 Transfer occurs on a port only when valid and ready are both high at a rising edge.
REQ-015 ROR SHALL yield {x[n-1:0], x[WIDTH-1:n]}; ROL = ROR by (WIDTH-n) mod WIDTH; SHR/SHL fill vacated bits with 0.
REQ-016 Amount 0 in any mode SHALL pass the operand unchanged.
REQ-017 Barrel decomposition: AW binary sub-shifts (1,2,4,...), distributed across STAGES register stages as evenly as possible, earlier stages taking the remainder.
REQ-018 Each stage SHALL carry valid, partial data, mode and remaining amount bits; amount and mode SHALL travel with their data.
REQ-019 Latency: STAGES cycles from input transfer to out_valid when out_ready is held high.
REQ-020 Throughput: one operation per cycle with out_ready high; no bubbles inserted.
REQ-021 Stage k SHALL advance when stage k+1 is empty or advancing; last stage advances on out_ready.
REQ-022 in_ready SHALL be high when stage 0 is empty or advancing (combinational from out_ready; no combinational path from in_valid to in_ready).
REQ-023 out_valid/out_data SHALL hold stable while out_valid high and out_ready low.
REQ-024 With out_ready low, pipeline SHALL fill and hold exactly STAGES operations, then drop in_ready; no operation lost or duplicated.
REQ-025 Bubbles SHALL collapse: an empty stage accepts new data even while downstream stalls.
REQ-026 Operations SHALL exit in acceptance order.
REQ-027 Simultaneous input and output transfer in the same cycle with full pipeline SHALL be permitted.

Reset
REQ-028 rst_n low SHALL asynchronously clear all stage valid bits; out_valid = 0, in_ready = 1 after reset deassertion.
REQ-029 Data/amount/mode registers need not reset; out_data is don't-care while out_valid = 0.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; no result emitted afterwards.

Structure
REQ-031 Mode encodings (MODE_ROR, MODE_ROL, MODE_SHR, MODE_SHL) SHALL live in the shared SHA package for reuse by message-schedule and compression blocks.
REQ-032 One sub-module rot_stage: combinational sub-shift group for one pipeline stage, parameterised by WIDTH and bit range of amount handled; rot_pipe instantiates STAGES copies and owns all registers.
REQ-033 Fixed-amount rotates elsewhere in the design remain combinational; rot_pipe serves runtime-amount use.

Verification (WIDTH=32, STAGES=2 unless stated)
REQ-034 ROR 0x80000001 by 1 -> 0xC0000000 after 2 cycles; ROL 0x12345678 by 8 -> 0x34567812.
REQ-035 SHR 0x80000000 by 31 -> 0x00000001; SHL 0xFFFFFFFF by 4 -> 0xFFFFFFF0; any mode amount 0 on 0xDEADBEEF -> 0xDEADBEEF.
REQ-036 Stream 16 random ops back-to-back, out_ready=1 -> 16 results in order, one per cycle, matching reference model.
REQ-037 Hold out_ready=0, drive 4 ops -> exactly 2 accepted, in_ready=0, out_data stable; release -> both emitted in order, then remaining 2.
REQ-038 Assert rst_n=0 with 2 ops in flight -> out_valid=0 immediately; after release no stale result appears.
REQ-039 Repeat REQ-036 for WIDTH=64, STAGES=6 and WIDTH=8, STAGES=1 with exhaustive amounts.
